// File: rtl/imem_loader_pkg.sv
// Shared types for the imem byte-stream loader: FSM state encoding and length validation.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StLenLo = 3'd1,
        StLenHi = 3'd2,
        StData  = 3'd3,
        StChk   = 3'd4,
        StDone  = 3'd5,
        StErr   = 3'd6
    } state_e;

    localparam int unsigned BytesPerWord = 4;

    // An image length is usable only if it is non-zero and fits in imem.
    function automatic logic len_bad(input logic [15:0] n, input int unsigned depth);
        return (n == 16'd0) || (32'(n) > depth);
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and imem write port of the loader, bundled for connection.
interface imem_loader_if #(
    parameter int unsigned ADDR_WIDTH = 8
);
    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic                  imem_we;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [31:0]           imem_wdata;

    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, imem_we, imem_addr, imem_wdata
    );

    modport master (
        output rx_data, rx_valid,
        input  rx_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/imem_loader_word_asm.sv
// Little-endian word assembler: collects four bytes and flags the byte that completes a word.
module imem_loader_word_asm (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word_data
);
    logic [1:0]  cnt_q;
    logic [23:0] part_q;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt_q  <= '0;
            part_q <= '0;
        end else if (byte_valid) begin
            cnt_q  <= cnt_q + 2'd1;
            part_q <= {byte_data, part_q[23:8]};
        end
    end

    // The completed word is presented combinationally on the cycle its last byte arrives.
    always_comb begin
        word_valid = byte_valid && (cnt_q == 2'd3);
        word_data  = {byte_data, part_q};
    end

endmodule

// File: rtl/imem_loader.sv
// Program loader: frames LEN_LO, LEN_HI, payload into imem writes and holds the CPU in reset
// until a valid image is in place. Define IMEM_LOADER_CHECKSUM_EN for a trailing XOR byte.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    imem_loader_if.slave        bus,
    output logic                cpu_reset,
    output logic                done,
    output logic                error,
    output logic [ADDR_WIDTH:0] word_count
);
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    state_e              state_q;
    logic [7:0]          len_lo_q;
    logic [ADDR_WIDTH:0] len_q;
    logic                rx_fire;
    logic                start_fire;
    logic                final_write;
    logic                asm_valid;
    logic                word_valid;
    logic [31:0]         word_data;
    logic [15:0]         len_in;

    always_comb begin
        rx_fire     = bus.rx_valid && bus.rx_ready;
        start_fire  = start && (state_q inside {StIdle, StDone, StErr});
        len_in      = {bus.rx_data, len_lo_q};
        // The write cycle of the last word: any byte accepted here is past the payload.
        final_write = (state_q == StData) && bus.imem_we && (word_count == len_q);
        asm_valid   = rx_fire && (state_q == StData) && !final_write;
    end

    imem_loader_word_asm u_word_asm (
        .clk        (clk),
        .reset      (reset),
        .clear      (start_fire),
        .byte_valid (asm_valid),
        .byte_data  (bus.rx_data),
        .word_valid (word_valid),
        .word_data  (word_data)
    );

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] chk_q;

    always_ff @(posedge clk) begin
        if (reset || start_fire) begin
            chk_q <= '0;
        end else if (asm_valid) begin
            chk_q <= chk_q ^ bus.rx_data;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StIdle;
            bus.rx_ready   <= 1'b0;
            bus.imem_we    <= 1'b0;
            bus.imem_addr  <= '0;
            bus.imem_wdata <= '0;
            cpu_reset      <= 1'b1;
            done           <= 1'b0;
            error          <= 1'b0;
            word_count     <= '0;
            len_lo_q       <= '0;
            len_q          <= '0;
        end else begin
            bus.imem_we <= 1'b0;
            unique case (state_q)
                StIdle, StDone, StErr: begin
                    if (start) begin
                        state_q      <= StLenLo;
                        bus.rx_ready <= 1'b1;
                        cpu_reset    <= 1'b1;
                        done         <= 1'b0;
                        error        <= 1'b0;
                        word_count   <= '0;
                    end
                end
                StLenLo: begin
                    if (rx_fire) begin
                        len_lo_q <= bus.rx_data;
                        state_q  <= StLenHi;
                    end
                end
                StLenHi: begin
                    if (rx_fire) begin
                        if (len_bad(len_in, DEPTH)) begin
                            state_q      <= StErr;
                            bus.rx_ready <= 1'b0;
                            error        <= 1'b1;
                        end else begin
                            state_q <= StData;
                            len_q   <= (ADDR_WIDTH + 1)'(len_in);
                        end
                    end
                end
                StData: begin
                    if (word_valid) begin
                        bus.imem_we    <= 1'b1;
                        bus.imem_addr  <= word_count[ADDR_WIDTH-1:0];
                        bus.imem_wdata <= word_data;
                        word_count     <= word_count + 1'b1;
                    end
                    if (final_write) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        // A checksum byte arriving back-to-back with the last word is judged now.
                        if (rx_fire) begin
                            bus.rx_ready <= 1'b0;
                            if (bus.rx_data == chk_q) begin
                                state_q   <= StDone;
                                done      <= 1'b1;
                                cpu_reset <= 1'b0;
                            end else begin
                                state_q <= StErr;
                                error   <= 1'b1;
                            end
                        end else begin
                            state_q <= StChk;
                        end
`else
                        state_q      <= StDone;
                        bus.rx_ready <= 1'b0;
                        done         <= 1'b1;
                        cpu_reset    <= 1'b0;
`endif
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                StChk: begin
                    if (rx_fire) begin
                        bus.rx_ready <= 1'b0;
                        if (bus.rx_data == chk_q) begin
                            state_q   <= StDone;
                            done      <= 1'b1;
                            cpu_reset <= 1'b0;
                        end else begin
                            state_q <= StErr;
                            error   <= 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    state_q      <= StIdle;
                    bus.rx_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: random framed images against a queue-based write model.
module tb_imem_loader;
    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 2 ** AW;

    typedef struct {
        int unsigned   cyc;
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        cpu_reset;
    logic        done;
    logic        error;
    logic [AW:0] word_count;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned cyc      = 0;
    int unsigned acc_cyc  = 0;

    wr_t         exp_q[$];
    wr_t         got_q[$];
    logic [31:0] img[$];

    imem_loader_if #(.ADDR_WIDTH(AW)) bus ();

    imem_loader #(.ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .bus        (bus),
        .cpu_reset  (cpu_reset),
        .done       (done),
        .error      (error),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.imem_we) got_q.push_back('{cyc, bus.imem_addr, bus.imem_wdata});
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called just after a negedge; returns on the negedge following the accepting edge.
    task automatic send_byte(input logic [7:0] b, input int unsigned gap);
        int unsigned t = 0;
        bus.rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        while (!bus.rx_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("rx_ready_for_byte", bus.rx_ready, 1'b1);
        @(negedge clk);
        acc_cyc      = cyc;
        bus.rx_valid = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic compare_writes(input string tag);
        check({tag, "_nwrites"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check($sformatf("%s_wr%0d_cyc", tag, i), got_q[i].cyc, exp_q[i].cyc);
            check($sformatf("%s_wr%0d_addr", tag, i), got_q[i].addr, exp_q[i].addr);
            check($sformatf("%s_wr%0d_data", tag, i), got_q[i].data, exp_q[i].data);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    // Loads img[0..n-1] as a frame of length n; poke issues a start while mid-payload.
    task automatic run_frame(input string tag, input logic [15:0] n, input int unsigned gmin,
                             input int unsigned gmax, input logic poke, input logic bad_chk);
        logic [7:0] b;
        logic       exp_ok;
`ifdef IMEM_LOADER_CHECKSUM_EN
        logic [7:0] chk = 8'h00;
`endif
        pulse_start();
        check({tag, "_start_cpu_reset"}, cpu_reset, 1'b1);
        check({tag, "_start_done"}, done, 1'b0);
        check({tag, "_start_error"}, error, 1'b0);
        check({tag, "_start_wcount"}, word_count, '0);
        check({tag, "_start_rx_ready"}, bus.rx_ready, 1'b1);
        send_byte(n[7:0], $urandom_range(gmax, gmin));
        send_byte(n[15:8], $urandom_range(gmax, gmin));
        if (n == 0 || n > DEPTH) begin
            check({tag, "_len_error"}, error, 1'b1);
            check({tag, "_len_cpu_reset"}, cpu_reset, 1'b1);
            check({tag, "_len_rx_ready"}, bus.rx_ready, 1'b0);
            check({tag, "_len_wcount"}, word_count, '0);
            repeat (3) @(negedge clk);
        end else begin
            for (int i = 0; i < n; i++) begin
                for (int k = 0; k < 4; k++) begin
                    if (poke && i == 1 && k == 0) pulse_start();
                    b = img[i][8*k +: 8];
`ifdef IMEM_LOADER_CHECKSUM_EN
                    chk ^= b;
`endif
                    send_byte(b, $urandom_range(gmax, gmin));
                    if (k == 3) exp_q.push_back('{acc_cyc, AW'(i), img[i]});
                end
            end
            exp_ok = !bad_chk;
`ifdef IMEM_LOADER_CHECKSUM_EN
            send_byte(bad_chk ? (chk ^ 8'h01) : chk, $urandom_range(gmax, 0));
`else
            @(negedge clk);
`endif
            check({tag, "_done"}, done, exp_ok);
            check({tag, "_error"}, error, !exp_ok);
            check({tag, "_cpu_reset"}, cpu_reset, !exp_ok);
            check({tag, "_wcount"}, word_count, (AW + 1)'(n));
            check({tag, "_end_rx_ready"}, bus.rx_ready, 1'b0);
            repeat (3) @(negedge clk);
        end
        compare_writes(tag);
    endtask

    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_cpu_reset", cpu_reset, 1'b1);
        check("rst_rx_ready", bus.rx_ready, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_error", error, 1'b0);
        check("rst_imem_we", bus.imem_we, 1'b0);
        check("rst_addr", bus.imem_addr, '0);
        check("rst_wdata", bus.imem_wdata, '0);
        check("rst_wcount", word_count, '0);

        img = '{32'h0000_0013, 32'h0010_0093};
        run_frame("basic", 16'd2, 0, 0, 1'b0, 1'b0);

        run_frame("len_zero", 16'd0, 0, 2, 1'b0, 1'b0);
        run_frame("len_over", 16'(DEPTH + 1), 0, 2, 1'b0, 1'b0);
        run_frame("len_max16", 16'hFFFF, 0, 0, 1'b0, 1'b0);

        for (int r = 0; r < 3; r++) begin
            img.delete();
            for (int i = 0; i < 3; i++) img.push_back($urandom);
            run_frame($sformatf("gapped%0d", r), 16'd3, 1, 5, r == 1, 1'b0);
        end

        img.delete();
        for (int i = 0; i < DEPTH; i++) img.push_back($urandom);
        run_frame("full_depth", 16'(DEPTH), 0, 1, 1'b0, 1'b0);

        // Reset mid-load after six payload bytes: one word written, then nothing more.
        img = '{$urandom, $urandom};
        pulse_start();
        send_byte(8'd2, 0);
        send_byte(8'd0, 0);
        for (int j = 0; j < 6; j++) begin
            send_byte(img[j/4][8*(j%4) +: 8], 0);
            if (j == 3) exp_q.push_back('{acc_cyc, AW'(0), img[0]});
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_cpu_reset", cpu_reset, 1'b1);
        check("midrst_rx_ready", bus.rx_ready, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_wcount", word_count, '0);
        bus.rx_valid = 1'b1;
        for (int j = 0; j < 8; j++) begin
            bus.rx_data = 8'($urandom);
            @(negedge clk);
        end
        bus.rx_valid = 1'b0;
        check("idle_rx_ready", bus.rx_ready, 1'b0);
        compare_writes("midrst");
        img = '{$urandom};
        run_frame("after_rst", 16'd1, 0, 2, 1'b0, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        img = '{32'h0000_0013};
        run_frame("chk_good", 16'd1, 1, 3, 1'b0, 1'b0);
        run_frame("chk_bad", 16'd1, 1, 3, 1'b0, 1'b1);
`endif

        img = '{$urandom, $urandom};
        run_frame("reload", 16'd2, 0, 3, 1'b0, 1'b0);

        // Reset and start together from DONE: reset must win.
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        check("rst_start_rx_ready", bus.rx_ready, 1'b0);
        check("rst_start_done", done, 1'b0);
        check("rst_start_cpu_reset", cpu_reset, 1'b1);
        repeat (2) @(negedge clk);
        compare_writes("tail");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
